pdp_med1d_core: RTL and testbench

//  Streaming 1-D median-of-3 stage for the PDP 3x3 median-pooling path.
//  - Keeps the last two accepted input words.
//  - Outputs the per-lane median of {current input, previous input, input before that}.
//  - Registers the result for the next pooling stage.
//  - Combines the combinational median core and its output register.

---
 rtl/pdp_med_pkg.sv | 38 +++
 rtl/pdp_med3_lane.sv | 24 ++
 rtl/pdp_med1d_core.sv | 113 +++++++++++
 tb/tb_pdp_med1d_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pdp_med_pkg.sv
// Shared types and helpers for the PDP median-pooling path.
// Holds data widths, the mode encoding and the median/fp16 ordering functions.
package pdp_med_pkg;

    localparam int unsigned DATA_W = 22;
    localparam int unsigned LANE_W = 11;

    typedef enum logic [1:0] {
        MODE_NONE,
        MODE_INT8,
        MODE_INT16,
        MODE_FP16
    } mode_e;

    // Narrower lanes sign-extend into DATA_W before calling this.
    function automatic logic [DATA_W-1:0] median3_signed(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic signed [DATA_W-1:0] c
    );
        logic signed [DATA_W-1:0] lo;
        logic signed [DATA_W-1:0] hi;
        logic signed [DATA_W-1:0] m;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m  = (hi < c) ? hi : c;
        return (lo > m) ? lo : m;
    endfunction

    // Unsigned ordering key; -0 maps onto the +0 key so signed zeros tie.
    function automatic logic [15:0] fp16_key(input logic [15:0] h);
        if (h[15] && (h[14:0] != 15'd0)) begin
            return {1'b0, ~h[14:0]};
        end
        return {1'b1, h[14:0]};
    endfunction

endpackage

// File: rtl/pdp_med3_lane.sv
// Combinational signed median-of-3 for one lane of width W (W <= DATA_W).
module pdp_med3_lane
    import pdp_med_pkg::*;
#(
    parameter int unsigned W = LANE_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] med
);

    logic signed [DATA_W-1:0] ax;
    logic signed [DATA_W-1:0] bx;
    logic signed [DATA_W-1:0] cx;

    always_comb begin
        ax  = DATA_W'($signed(a));
        bx  = DATA_W'($signed(b));
        cx  = DATA_W'($signed(c));
        med = W'(median3_signed(ax, bx, cx));
    end

endmodule

// File: rtl/pdp_med1d_core.sv
// Streaming 1-D median-of-3 stage: two-word history, per-mode median, registered output.
module pdp_med1d_core
    import pdp_med_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              core_enable,
    input  logic              reg2dp_int8_en,
    input  logic              reg2dp_int16_en,
    input  logic              reg2dp_fp16_en,
    input  logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] pooling_median,
    output logic [DATA_W-1:0] pooling_median_q
);

    localparam int unsigned PadW = DATA_W - 16;

    mode_e             mode;
    logic [DATA_W-1:0] h1_q;
    logic [DATA_W-1:0] h2_q;
    logic [LANE_W-1:0] lane_lo;
    logic [LANE_W-1:0] lane_hi;
    logic [DATA_W-1:0] wide_a;
    logic [DATA_W-1:0] wide_b;
    logic [DATA_W-1:0] wide_c;
    logic [DATA_W-1:0] wide_med;
    logic [15:0]       key_a;
    logic [15:0]       key_b;
    logic [15:0]       key_c;
    logic [15:0]       fp_sel;

    always_comb begin
        mode = MODE_NONE;
        if (reg2dp_int8_en) begin
            mode = MODE_INT8;
        end else if (reg2dp_int16_en) begin
            mode = MODE_INT16;
        end else if (reg2dp_fp16_en) begin
            mode = MODE_FP16;
        end
    end

    // The wide lane is shared: raw words for int16, zero-extended ordering keys for fp16.
    always_comb begin
        key_a = fp16_key(data0[15:0]);
        key_b = fp16_key(h1_q[15:0]);
        key_c = fp16_key(h2_q[15:0]);
        if (mode == MODE_FP16) begin
            wide_a = {{PadW{1'b0}}, key_a};
            wide_b = {{PadW{1'b0}}, key_b};
            wide_c = {{PadW{1'b0}}, key_c};
        end else begin
            wide_a = data0;
            wide_b = h1_q;
            wide_c = h2_q;
        end
    end

    pdp_med3_lane #(.W(LANE_W)) u_lane_lo (
        .a   (data0[LANE_W-1:0]),
        .b   (h1_q[LANE_W-1:0]),
        .c   (h2_q[LANE_W-1:0]),
        .med (lane_lo)
    );

    pdp_med3_lane #(.W(LANE_W)) u_lane_hi (
        .a   (data0[DATA_W-1:LANE_W]),
        .b   (h1_q[DATA_W-1:LANE_W]),
        .c   (h2_q[DATA_W-1:LANE_W]),
        .med (lane_hi)
    );

    pdp_med3_lane #(.W(DATA_W)) u_lane_wide (
        .a   (wide_a),
        .b   (wide_b),
        .c   (wide_c),
        .med (wide_med)
    );

    // Map the winning key back to the original half-precision bits.
    always_comb begin
        if (wide_med[15:0] == key_a) begin
            fp_sel = data0[15:0];
        end else if (wide_med[15:0] == key_b) begin
            fp_sel = h1_q[15:0];
        end else begin
            fp_sel = h2_q[15:0];
        end
    end

    always_comb begin
        pooling_median = '0;
        unique case (mode)
            MODE_INT8:  pooling_median = {lane_hi, lane_lo};
            MODE_INT16: pooling_median = wide_med;
            MODE_FP16:  pooling_median = {{PadW{1'b0}}, fp_sel};
            default:    pooling_median = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_q             <= '0;
            h2_q             <= '0;
            pooling_median_q <= '0;
        end else if (core_enable) begin
            h2_q             <= h1_q;
            h1_q             <= data0;
            pooling_median_q <= pooling_median;
        end
    end

endmodule

// File: tb/tb_pdp_med1d_core.sv
// Self-checking bench for pdp_med1d_core: vector table plus scoreboard for the registered output.
module tb_pdp_med1d_core;

    logic        clk;
    logic        rst;
    logic        core_enable;
    logic        reg2dp_int8_en;
    logic        reg2dp_int16_en;
    logic        reg2dp_fp16_en;
    logic [21:0] data0;
    logic [21:0] pooling_median;
    logic [21:0] pooling_median_q;

    pdp_med1d_core dut (
        .clk              (clk),
        .rst              (rst),
        .core_enable      (core_enable),
        .reg2dp_int8_en   (reg2dp_int8_en),
        .reg2dp_int16_en  (reg2dp_int16_en),
        .reg2dp_fp16_en   (reg2dp_fp16_en),
        .data0            (data0),
        .pooling_median   (pooling_median),
        .pooling_median_q (pooling_median_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        i8;
        logic        i16;
        logic        f16;
        logic [21:0] d;
        logic [21:0] exp;
        bit          zok;  // any zero pattern (+0 or -0) is acceptable
    } vec_t;

    typedef struct {
        logic [21:0] v;
        bit          zok;
    } qexp_t;

    localparam int NVEC = 22;

    vec_t  tbl[NVEC];
    qexp_t sb[$];
    qexp_t last_q;
    int    n_checks;
    int    n_fail;

    function automatic vec_t mk(input logic en, input logic [2:0] m, input logic [21:0] d,
                                input logic [21:0] exp, input bit zok);
        vec_t v;
        v.en  = en;
        v.i8  = m[2];
        v.i16 = m[1];
        v.f16 = m[0];
        v.d   = d;
        v.exp = exp;
        v.zok = zok;
        return v;
    endfunction

    task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp,
                       input bit zok);
        bit ok;
        n_checks++;
        if (zok) ok = (act[21:16] == 6'd0) && (act[14:0] == 15'd0);
        else     ok = (act === exp);
        if (!ok) begin
            n_fail++;
            if (zok) $display("FAIL %s: got 0x%06h, want an fp16 zero pattern", name, act);
            else     $display("FAIL %s: got 0x%06h, want 0x%06h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        qexp_t e;
        core_enable     = v.en;
        reg2dp_int8_en  = v.i8;
        reg2dp_int16_en = v.i16;
        reg2dp_fp16_en  = v.f16;
        data0           = v.d;
        #1;
        chk({tag, " comb"}, pooling_median, v.exp, v.zok);
        if (v.en) begin
            last_q.v   = v.exp;
            last_q.zok = v.zok;
        end
        sb.push_back(last_q);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s q: scoreboard empty, got 0x%06h", tag, pooling_median_q);
        end else begin
            e = sb.pop_front();
            chk({tag, " q"}, pooling_median_q, e.v, e.zok);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_q.v   = '0;
        last_q.zok = 1'b0;

        // mode field: {int8, int16, fp16}
        tbl[0]  = mk(1, 3'b100, 22'h000005, 22'h000000, 0);
        tbl[1]  = mk(1, 3'b100, 22'h000003, 22'h000003, 0);
        tbl[2]  = mk(1, 3'b100, 22'h000009, 22'h000005, 0);
        tbl[3]  = mk(1, 3'b100, 22'h000FFF, 22'h000003, 0);
        tbl[4]  = mk(1, 3'b100, 22'h003802, 22'h000802, 0);
        tbl[5]  = mk(1, 3'b100, 22'h0027FD, 22'h0027FF, 0);
        tbl[6]  = mk(1, 3'b010, 22'h3FFFFF, 22'h0027FD, 0);
        tbl[7]  = mk(0, 3'b110, 22'h000010, 22'h0007FF, 0);
        tbl[8]  = mk(1, 3'b010, 22'h000010, 22'h000010, 0);
        tbl[9]  = mk(1, 3'b010, 22'h000002, 22'h000002, 0);
        tbl[10] = mk(0, 3'b000, 22'h000123, 22'h000000, 0);
        tbl[11] = mk(1, 3'b001, 22'h003C00, 22'h000010, 0);
        tbl[12] = mk(1, 3'b001, 22'h00BC00, 22'h000002, 0);
        tbl[13] = mk(1, 3'b001, 22'h004000, 22'h003C00, 0);
        tbl[14] = mk(1, 3'b001, 22'h008000, 22'h000000, 1);
        tbl[15] = mk(1, 3'b001, 22'h000000, 22'h000000, 1);
        tbl[16] = mk(1, 3'b001, 22'h003C00, 22'h000000, 1);
        tbl[17] = mk(1, 3'b001, 22'h3FC000, 22'h000000, 0);
        tbl[18] = mk(0, 3'b001, 22'h004000, 22'h003C00, 0);
        tbl[19] = mk(0, 3'b001, 22'h004200, 22'h003C00, 0);
        tbl[20] = mk(0, 3'b001, 22'h00C200, 22'h00C000, 0);
        tbl[21] = mk(1, 3'b001, 22'h004400, 22'h003C00, 0);

        rst             = 1'b1;
        core_enable     = 1'b0;
        reg2dp_int8_en  = 1'b0;
        reg2dp_int16_en = 1'b0;
        reg2dp_fp16_en  = 1'b0;
        data0           = '0;
        repeat (2) @(negedge clk);
        chk("reset q", pooling_median_q, 22'h0, 0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of the high phase, no clock edge involved.
        #2;
        rst             = 1'b1;
        core_enable     = 1'b1;
        reg2dp_int8_en  = 1'b1;
        reg2dp_int16_en = 1'b0;
        reg2dp_fp16_en  = 1'b0;
        data0           = 22'h000005;
        #1;
        chk("async rst q", pooling_median_q, 22'h0, 0);
        chk("async rst h1", dut.h1_q, 22'h0, 0);
        chk("async rst h2", dut.h2_q, 22'h0, 0);
        chk("async rst comb", pooling_median, 22'h0, 0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        last_q.v   = '0;
        last_q.zok = 1'b0;
        sb.delete();

        step(mk(1, 3'b100, 22'h000005, 22'h000000, 0), "post-rst a");
        step(mk(1, 3'b100, 22'h000003, 22'h000003, 0), "post-rst b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
